// File: rtl/read_master.sv
// Avalon-MM pipelined read master with a show-ahead return FIFO.
// Requests stop issuing once FIFO occupancy plus reads in flight reaches the depth.
module read_master #(
   parameter int AVALON_DATA_WIDTH        = 32,
   parameter int AVALON_ADDRESS_WIDTH     = 32,
   parameter int FIFO_DEPTH               = 16,
   parameter int FIFO_DEPTH_LOG2          = 4,
   parameter int AVALON_BYTE_ENABLE_WIDTH = AVALON_DATA_WIDTH / 8
) (
   input  logic                                M_AVALON_CLK,
   input  logic                                M_AVALON_RSTN,
   input  logic                                control_fixed_location,
   input  logic [AVALON_ADDRESS_WIDTH-1:0]     control_read_base,
   input  logic [AVALON_ADDRESS_WIDTH-1:0]     control_read_length,
   input  logic                                control_go,
   output logic                                control_done,
   output logic                                control_early_done,
   input  logic                                user_read_buffer,
   output logic [AVALON_DATA_WIDTH-1:0]        user_buffer_data,
   output logic                                user_data_available,
   input  logic                                M_AVALON_WAITREQUEST,
   input  logic [AVALON_DATA_WIDTH-1:0]        M_AVALON_READDATA,
   input  logic                                M_AVALON_READDATAVALID,
   output logic [AVALON_ADDRESS_WIDTH-1:0]     M_AVALON_ADDRESS,
   output logic                                M_AVALON_READ,
   output logic [AVALON_BYTE_ENABLE_WIDTH-1:0] M_AVALON_BYTEENABLE
);

   localparam int AW = AVALON_ADDRESS_WIDTH;
   localparam int DW = AVALON_DATA_WIDTH;
   localparam int LG = FIFO_DEPTH_LOG2;

   localparam logic [AW-1:0] STEP    = AW'(AVALON_BYTE_ENABLE_WIDTH);
   localparam logic [LG+1:0] DEPTH_C = (LG + 2)'(FIFO_DEPTH);
   localparam logic [LG:0]   ONE_C   = (LG + 1)'(1);
   localparam logic [LG-1:0] PONE_C  = LG'(1);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] len_q, len_d;
   logic [LG:0]   pend_q, pend_d;
   logic [LG:0]   used_q, used_d;
   logic [LG-1:0] wr_ptr_q, wr_ptr_d;
   logic [LG-1:0] rd_ptr_q, rd_ptr_d;
   logic          fixed_q, fixed_d;
   logic [DW-1:0] mem_q [FIFO_DEPTH];

   logic [LG+1:0] occ;
   logic          rd_en;
   logic          accept;
   logic          ret;
   logic          pop;
   logic          done;

   always_comb begin
      occ    = {1'b0, used_q} + {1'b0, pend_q};
      rd_en  = (len_q != '0) && (occ < DEPTH_C);
      accept = rd_en && !M_AVALON_WAITREQUEST;
      ret    = M_AVALON_READDATAVALID && (pend_q != '0);
      pop    = user_read_buffer && (used_q != '0);
      done   = (len_q == '0) && (pend_q == '0);

      addr_d   = addr_q;
      len_d    = len_q;
      fixed_d  = fixed_q;
      pend_d   = pend_q;
      used_d   = used_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (control_go && done) begin
         addr_d  = control_read_base;
         len_d   = control_read_length;
         fixed_d = control_fixed_location;
      end else if (accept) begin
         len_d = (len_q < STEP) ? '0 : len_q - STEP;
         if (!fixed_q) begin
            addr_d = addr_q + STEP;
         end
      end

      unique case ({accept, ret})
         2'b10:   pend_d = pend_q + ONE_C;
         2'b01:   pend_d = pend_q - ONE_C;
         default: pend_d = pend_q;
      endcase

      unique case ({ret, pop})
         2'b10:   used_d = used_q + ONE_C;
         2'b01:   used_d = used_q - ONE_C;
         default: used_d = used_q;
      endcase

      if (ret) begin
         wr_ptr_d = wr_ptr_q + PONE_C;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PONE_C;
      end
   end

   always_ff @(posedge M_AVALON_CLK) begin
      if (!M_AVALON_RSTN) begin
         addr_q   <= '0;
         len_q    <= '0;
         fixed_q  <= 1'b0;
         pend_q   <= '0;
         used_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         addr_q   <= addr_d;
         len_q    <= len_d;
         fixed_q  <= fixed_d;
         pend_q   <= pend_d;
         used_q   <= used_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge M_AVALON_CLK) begin
      if (M_AVALON_RSTN && ret) begin
         mem_q[wr_ptr_q] <= M_AVALON_READDATA;
      end
   end

   assign M_AVALON_ADDRESS    = addr_q;
   assign M_AVALON_READ       = rd_en;
   assign M_AVALON_BYTEENABLE = '1;
   assign user_buffer_data    = mem_q[rd_ptr_q];
   assign user_data_available = (used_q != '0);
   assign control_early_done  = (len_q == '0);
   assign control_done        = done;

endmodule

// File: tb/tb_read_master.sv
// Randomized bench for read_master: an Avalon slave model plus a
// scoreboard of expected addresses and FIFO data derived from base/length.
module tb_read_master;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          fixed_loc = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] len = '0;
   logic          go = 1'b0;
   logic          done;
   logic          early_done;
   logic          user_read;
   logic [DW-1:0] user_data;
   logic          avail;
   logic          waitreq;
   logic [DW-1:0] rdata;
   logic          rdv;
   logic [AW-1:0] addr;
   logic          rd;
   logic [3:0]    be;

   read_master dut (
      .M_AVALON_CLK           (clk),
      .M_AVALON_RSTN          (rstn),
      .control_fixed_location (fixed_loc),
      .control_read_base      (base),
      .control_read_length    (len),
      .control_go             (go),
      .control_done           (done),
      .control_early_done     (early_done),
      .user_read_buffer       (user_read),
      .user_buffer_data       (user_data),
      .user_data_available    (avail),
      .M_AVALON_WAITREQUEST   (waitreq),
      .M_AVALON_READDATA      (rdata),
      .M_AVALON_READDATAVALID (rdv),
      .M_AVALON_ADDRESS       (addr),
      .M_AVALON_READ          (rd),
      .M_AVALON_BYTEENABLE    (be)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } ret_t;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   ret_t        slv_q[$];

   int   cyc = 0;
   int   acc_cnt = 0;
   int   stall_cnt = 0;
   int   model_pend = 0;
   int   model_used = 0;
   int   last_due = 0;
   int   lat = 3;
   int   wait_pct = 0;
   int   pop_mode = 0;
   int   pop_credit = 0;
   int   hold_cnt = 0;
   int   hold_trigger = -1;
   int   last_rdv_edge = 0;
   int   done_rise = 0;
   logic prev_done = 1'b1;
   logic prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_f(logic [31:0] a);
      return (a * 32'h9E3779B1) ^ (a >> 3) ^ 32'hA5A5_0000;
   endfunction

   // Slave and user stimulus, driven just after each rising edge.
   initial begin
      waitreq = 1'b0;
      rdv = 1'b0;
      rdata = '0;
      user_read = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (hold_trigger >= 0 && acc_cnt == hold_trigger) begin
            hold_cnt = 5;
            hold_trigger = -1;
         end
         if (hold_cnt > 0) begin
            waitreq = 1'b1;
            hold_cnt--;
         end else begin
            waitreq = ($urandom_range(99) < wait_pct);
         end
         user_read = (pop_mode == 2) || (pop_credit > 0) ||
                     (pop_mode == 1 && $urandom_range(1) == 1);
         rdv = 1'b0;
         rdata = $urandom;
         if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
            rdv = 1'b1;
            rdata = slv_q[0].data;
            void'(slv_q.pop_front());
         end
      end
   end

   // Monitor: predicts what the coming edge does and checks against the model.
   always @(negedge clk) begin
      logic acc;
      logic pop;
      logic ret;
      int   due;
      if (!rstn) begin
         model_pend = 0;
         model_used = 0;
         prev_stall = 1'b0;
         prev_done = 1'b1;
      end else begin
         check("avail", avail, model_used != 0);
         check("done", done, exp_addr.size() == 0 && model_pend == 0);
         check("early_done", early_done, exp_addr.size() == 0);
         check("issue_rule", rd,
               exp_addr.size() != 0 && (model_used + model_pend) < 16);
         if (prev_stall) begin
            check("read_held", rd, 1);
            check("addr_held", addr, prev_addr);
         end
         prev_stall = rd && waitreq;
         if (prev_stall) stall_cnt++;
         prev_addr = addr;
         if (done && !prev_done) done_rise = cyc;
         prev_done = done;

         acc = rd && !waitreq;
         pop = user_read && avail;
         ret = rdv && (model_pend > 0);
         if (acc) begin
            acc_cnt++;
            if (exp_addr.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_read: got addr %0h expected no read", addr);
            end else begin
               check("address", addr, exp_addr.pop_front());
            end
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            slv_q.push_back('{due, mem_f(addr)});
            model_pend++;
         end
         if (ret) begin
            model_pend--;
            model_used++;
            last_rdv_edge = cyc + 1;
         end
         if (pop) begin
            model_used--;
            if (pop_credit > 0) pop_credit--;
            if (exp_data.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_data: got %0h expected empty", user_data);
            end else begin
               check("fifo_data", user_data, exp_data.pop_front());
            end
         end
      end
   end

   task automatic do_go(logic [31:0] b, logic [31:0] l, logic f);
      bit ok;
      @(posedge clk);
      #2;
      ok = (exp_addr.size() == 0 && model_pend == 0);
      go = 1'b1;
      base = b;
      len = l;
      fixed_loc = f;
      @(posedge clk);
      #2;
      go = 1'b0;
      if (ok) begin
         for (int i = 0; i < int'((l + 3) / 4); i++) begin
            logic [31:0] a;
            a = f ? b : b + 32'(4 * i);
            exp_addr.push_back(a);
            exp_data.push_back(mem_f(a));
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(exp_addr.size() == 0 && model_pend == 0 &&
               model_used == 0 && exp_data.size() == 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 5000, 1);
      @(negedge clk);
   endtask

   initial begin
      int a0;
      int s0;
      int n;
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b1;
      @(negedge clk);
      check("rst_read", rd, 0);
      check("rst_addr", addr, 0);
      check("rst_done", done, 1);
      check("rst_early", early_done, 1);
      check("rst_avail", avail, 0);
      check("byteenable", be, 4'hF);

      // Back-to-back issue at 0x1000, latency 3, no stalls.
      lat = 3; wait_pct = 0; pop_mode = 2;
      a0 = acc_cnt;
      do_go(32'h1000, 16, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      check("b2b_accepts", acc_cnt - a0, 4);
      wait_idle();
      check("done_after_last_rdv", done_rise, last_rdv_edge);

      // Five-cycle stall on the second read.
      a0 = acc_cnt; s0 = stall_cnt;
      hold_trigger = acc_cnt + 1;
      do_go(32'h1000, 32, 1'b0);
      wait_idle();
      check("stall_accepts", acc_cnt - a0, 8);
      check("stall_cycles", stall_cnt - s0, 5);

      // Backpressure: no pops, reads stop at FIFO depth.
      pop_mode = 0; lat = 2;
      a0 = acc_cnt;
      do_go(32'h0, 128, 1'b0);
      repeat (60) @(posedge clk);
      @(negedge clk);
      check("bp_accepts", acc_cnt - a0, 16);
      check("bp_read_low", rd, 0);
      check("bp_early", early_done, 0);
      pop_credit = 1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("bp_one_more", acc_cnt - a0, 17);
      pop_mode = 2;
      wait_idle();
      check("bp_total", acc_cnt - a0, 32);

      // Fixed location.
      a0 = acc_cnt;
      do_go(32'h2000, 12, 1'b1);
      wait_idle();
      check("fixed_accepts", acc_cnt - a0, 3);

      // Full FIFO with random concurrent pop/return.
      pop_mode = 0; lat = 2;
      a0 = acc_cnt;
      do_go(32'h3000, 100, 1'b0);
      repeat (40) @(posedge clk);
      pop_mode = 1;
      wait_idle();
      check("full_accepts", acc_cnt - a0, 25);

      // Reset with three reads in flight.
      pop_mode = 0; lat = 20;
      a0 = acc_cnt;
      hold_trigger = acc_cnt + 3;
      do_go(32'h4000, 64, 1'b0);
      n = 0;
      while (acc_cnt - a0 < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_wait", n < 100, 1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      @(posedge clk);
      #2;
      rstn = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("rst_mid_slave_drained", slv_q.size(), 0);
      check("rst_mid_avail", avail, 0);
      check("rst_mid_done", done, 1);
      check("rst_mid_read", rd, 0);

      // Go while busy is ignored.
      lat = 3; pop_mode = 2;
      a0 = acc_cnt;
      do_go(32'h5000, 40, 1'b0);
      repeat (3) @(posedge clk);
      do_go(32'h9000, 8, 1'b1);
      wait_idle();
      check("busy_go_accepts", acc_cnt - a0, 10);

      // Length not a multiple of the word size.
      a0 = acc_cnt;
      do_go(32'h6000, 6, 1'b0);
      wait_idle();
      check("len6_accepts", acc_cnt - a0, 2);
      check("len6_early", early_done, 1);

      // Randomized transfers.
      for (int t = 0; t < 20; t++) begin
         logic [31:0] rb;
         logic [31:0] rl;
         logic        rf;
         rb = {14'h0, 16'($urandom_range(0, 65535)), 2'b00};
         rl = 32'($urandom_range(0, 90));
         rf = 1'($urandom_range(0, 3) == 0);
         lat = $urandom_range(1, 6);
         wait_pct = $urandom_range(0, 40);
         pop_mode = $urandom_range(1, 2);
         a0 = acc_cnt;
         do_go(rb, rl, rf);
         wait_idle();
         check("rand_accepts", acc_cnt - a0, (rl + 3) / 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
